dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the data-cache line interface (`drequest`/`dreqack`/`ddone`). It accepts one 64-byte line request at a time from the data cache, either a write-back or a line fill. It splits the line into eight 64-bit beats on a pipelined word-wide memory port, then returns completion, plus the full line for reads, to the cache. It sits between the data cache and the system memory bus.

## Interface
- `WordSize`, 64: beat width in bits; the memory port width.
- `LineWords`, 8: beats per line; `LineWords*WordSize` = 512 = line width.
- `clk`  in  1: the only clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `drequest`  in  1: cache request valid; held until `dreqack`.
- `dwrenable`  in  1: 1 = line write-back, 0 = line read; sampled with `drequest`.
- `daddr`  in  64: line address; bits [5:0] are ignored and treated as 0.
- `dwdata`  in  512: write line; beat i = `dwdata[64*i+:64]`.
- `dreqack`  out  1: one-cycle pulse, request captured.
- `drdata`  out  512: read line; beat i = `drdata[64*i+:64]`.
- `ddone`  out  1: one-cycle pulse, transaction complete.
- `mem_req`  out  1: beat request valid.
- `mem_we`  out  1: beat is a write.
- `mem_addr`  out  64: beat byte address = line base + 8*i.
- `mem_wdata`  out  64: write beat data.
- `mem_ready`  in  1: memory accepts the beat when `mem_req && mem_ready`.
- `mem_rvalid`  in  1: read beat returned; responses arrive in issue order.
- `mem_rdata`  in  64: returned beat data.
- `proto_err`  out  1: sticky flag for an unexpected `mem_rvalid`.

## Operation
- States:
  - IDLE: on `drequest`, capture base = {`daddr`[63:6], 6'b0}, `dwrenable` and `dwdata`. Pulse `dreqack` the next cycle, clear `issue_idx`/`ret_idx`, go to XFER.
  - XFER: issue beats, and collect read beats.
  - Return to IDLE with a `ddone` pulse in the cycle after completion.
- Issue (XFER): `mem_req` = (`issue_idx` < 8). `mem_we`/`mem_addr`/`mem_wdata` come only from registered state (Moore outputs). Each accepted beat increments `issue_idx` (4-bit, saturates at 8).
- Read collect: each `mem_rvalid` while in XFER on a read with `ret_idx` < 8 writes `mem_rdata` into `drdata[64*ret_idx+:64]` and increments `ret_idx`. A beat may return in the same cycle another beat issues.
- Completion:
  - Write: when the 8th beat is accepted (writes are posted).
  - Read: when the 8th beat returns.
  - On the completing edge: `ddone`<=1, state<=IDLE.
- `drdata` is valid in the `ddone` cycle and held until the next read overwrites it beat by beat. Write transactions never modify `drdata`.
- `drequest` is ignored outside IDLE. A request that stays high after `dreqack` is not re-accepted until IDLE.
- `proto_err` is set by `mem_rvalid` in IDLE, in XFER on a write, or with `ret_idx` == 8. The data is discarded; only `reset` clears the flag.

## Timing
- Reset values: `dreqack`=0, `ddone`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `drdata`=0, `proto_err`=0. State=IDLE, counters=0.
- Request latency:
  - `drequest` sampled high in IDLE at edge N: `dreqack` is high in cycle N+1, together with the first `mem_req`.
- Ideal-memory latency (`mem_ready`=1, `rvalid` 1 cycle after accept):
  - Write: `ddone` 9 cycles after `dreqack`.
  - Read: `ddone` 10 cycles after `dreqack`.
- `ddone` never coincides with `dreqack`.
- In the `ddone` cycle the block is in IDLE and may accept a new `drequest` sampled at that edge. A back-to-back write-back then fill therefore works with no idle gap.
- `mem_ready` low stalls the beat: `mem_addr`/`mem_wdata` are held stable until accepted.
- Reset mid-transfer: abandon immediately and return to IDLE with no `ddone`. `mem_rvalid` after the reset is ignored and does not set `proto_err` until a new request starts.

## Test plan
- Read, ideal memory; memory word at 0x1000+8i = 0xA0+i, `daddr`=0x1000 -> `dreqack` at N+1; `mem_addr` 0x1000..0x1038; `ddone` at N+11; `drdata[64*i+:64]`=0xA0+i.
- Write-back, `daddr`=0x2000, `dwdata` beat i = i -> 8 write beats, addrs 0x2000..0x2038, data 0..7; `ddone` 9 cycles after `dreqack`; `drdata` unchanged.
- `mem_ready` toggling 1,0,0,1,... plus `rvalid` latency 3 -> beats in order; address and data stable while stalled; correct line returned; exactly one `ddone`.
- Write-back whose `ddone` cycle sees `drequest`=1 for a read of 0x3000 -> `dreqack` in the next cycle; fill completes correctly.
- `daddr`=0x103F -> base treated as 0x1000.
- Stray `mem_rvalid` in IDLE -> `proto_err`=1 and held.
- `reset` asserted at read beat 4 -> outputs zeroed next cycle, no `ddone`. A following read of 0x4000 completes normally.

Source files
------------

// File: rtl/dmem_responder.sv
// Memory-side responder for the data-cache line interface: splits one 64-byte
// line request into eight pipelined word beats and returns completion (plus read data).
module dmem_responder #(
    parameter int WordSize  = 64,
    parameter int LineWords = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          drequest,
    input  logic                          dwrenable,
    input  logic [63:0]                   daddr,
    input  logic [LineWords*WordSize-1:0] dwdata,
    output logic                          dreqack,
    output logic [LineWords*WordSize-1:0] drdata,
    output logic                          ddone,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [63:0]                   mem_addr,
    output logic [WordSize-1:0]           mem_wdata,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [WordSize-1:0]           mem_rdata,
    output logic                          proto_err
);

    localparam int              BeatW     = $clog2(LineWords);
    localparam int              IdxW      = BeatW + 1;
    localparam logic [63:0]     LineMask  = 64'(LineWords * WordSize / 8 - 1);
    localparam logic [63:0]     BeatBytes = 64'(WordSize / 8);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(LineWords);
    localparam logic [IdxW-1:0] LastBeat  = IdxW'(LineWords - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t              state_reg;
    logic                we_reg;
    logic                armed_reg;
    logic [IdxW-1:0]     issue_idx_reg;
    logic [IdxW-1:0]     ret_idx_reg;
    logic                dreqack_reg;
    logic                ddone_reg;
    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [63:0]         mem_addr_reg;
    logic [WordSize-1:0] mem_wdata_reg;
    logic                proto_err_reg;
    logic [WordSize-1:0] wline_reg [LineWords];

    logic             capture;
    logic             accept;
    logic             collect;
    logic             complete;
    logic             stray;
    logic [BeatW-1:0] next_beat;

    always_comb begin
        capture   = (state_reg == IDLE) && drequest;
        accept    = (state_reg == XFER) && mem_req_reg && mem_ready && (issue_idx_reg < LastIdx);
        collect   = (state_reg == XFER) && !we_reg && mem_rvalid && (ret_idx_reg < LastIdx);
        complete  = (state_reg == XFER) &&
                    (we_reg ? (issue_idx_reg == LastIdx) : (ret_idx_reg == LastIdx));
        // armed_reg masks late read beats from a transfer abandoned by reset
        stray     = mem_rvalid &&
                    (((state_reg == IDLE) && armed_reg) ||
                     ((state_reg == XFER) && (we_reg || (ret_idx_reg == LastIdx))));
        next_beat = issue_idx_reg[BeatW-1:0] + BeatW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            armed_reg     <= 1'b0;
            issue_idx_reg <= '0;
            ret_idx_reg   <= '0;
            dreqack_reg   <= 1'b0;
            ddone_reg     <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            dreqack_reg <= capture;
            ddone_reg   <= complete;
            if (stray) begin
                proto_err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (drequest) begin
                        state_reg     <= XFER;
                        we_reg        <= dwrenable;
                        armed_reg     <= 1'b1;
                        issue_idx_reg <= '0;
                        ret_idx_reg   <= '0;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= dwrenable;
                        mem_addr_reg  <= daddr & ~LineMask;
                        mem_wdata_reg <= dwdata[WordSize-1:0];
                    end
                end
                XFER: begin
                    if (accept) begin
                        issue_idx_reg <= issue_idx_reg + IdxW'(1);
                        // Beat outputs advance only on acceptance, so a stall holds them
                        if (issue_idx_reg < LastBeat) begin
                            mem_addr_reg  <= mem_addr_reg + BeatBytes;
                            mem_wdata_reg <= wline_reg[next_beat];
                        end else begin
                            mem_req_reg <= 1'b0;
                        end
                    end
                    if (collect) begin
                        ret_idx_reg <= ret_idx_reg + IdxW'(1);
                    end
                    if (complete) begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LineWords; i++) begin
                wline_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < LineWords; i++) begin
                wline_reg[i] <= dwdata[i*WordSize +: WordSize];
            end
        end
    end

    // Read line storage: each beat slot is overwritten only by its own returning beat
    for (genvar gi = 0; gi < LineWords; gi++) begin : g_beat
        logic [WordSize-1:0] rbeat_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                rbeat_reg <= '0;
            end else if (collect && (ret_idx_reg[BeatW-1:0] == BeatW'(gi))) begin
                rbeat_reg <= mem_rdata;
            end
        end

        assign drdata[gi*WordSize +: WordSize] = rbeat_reg;
    end

    assign dreqack   = dreqack_reg;
    assign ddone     = ddone_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected beats/lines,
// a negedge memory model and monitor pop and compare.
module tb_dmem_responder;

    localparam int W = 64;
    localparam int L = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           drequest;
    logic           dwrenable;
    logic [63:0]    daddr;
    logic [L*W-1:0] dwdata;
    logic           dreqack;
    logic [L*W-1:0] drdata;
    logic           ddone;
    logic           mem_req;
    logic           mem_we;
    logic [63:0]    mem_addr;
    logic [W-1:0]   mem_wdata;
    logic           mem_ready;
    logic           mem_rvalid;
    logic [W-1:0]   mem_rdata;
    logic           proto_err;

    dmem_responder #(.WordSize(W), .LineWords(L)) dut (
        .clk(clk), .reset(reset), .drequest(drequest), .dwrenable(dwrenable),
        .daddr(daddr), .dwdata(dwdata), .dreqack(dreqack), .drdata(drdata),
        .ddone(ddone), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        logic [L*W-1:0] line;
        int             lat;
        string          name;
    } txn_t;

    typedef struct {
        logic [63:0] data;
        int          due;
    } ret_t;

    beat_t       beat_q[$];
    txn_t        txn_q[$];
    ret_t        ret_q[$];
    logic [63:0] mem_model [logic [63:0]];

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int lat = 1;
    int accepts = 0;
    int ready_ctr = 0;
    int stray_cnt = 0;
    int stray_done = 0;
    int ack_cyc = 0;

    function automatic void chk(input string nm, input logic [L*W-1:0] act,
                                input logic [L*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [L*W-1:0] mk_line(input logic [63:0] first);
        logic [L*W-1:0] line;
        for (int i = 0; i < L; i++) begin
            line[64*i +: 64] = first + 64'(i);
        end
        return line;
    endfunction

    // Memory model and monitor, all sampled at negedge
    initial begin
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            begin
                ret_t  r;
                beat_t b;
                txn_t  t;
                logic  rdy;
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
                if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                    r = ret_q.pop_front();
                    mem_rvalid = 1'b1;
                    mem_rdata  = r.data;
                end else if (stray_cnt != stray_done) begin
                    stray_done++;
                    mem_rvalid = 1'b1;
                    mem_rdata  = 64'hBAD0_BAD0;
                end
                if (reset) begin
                    txn_q.delete();
                    beat_q.delete();
                    mem_ready = 1'b1;
                end else begin
                    rdy = (ready_mode == 0) ? 1'b1 : (ready_ctr % 3 == 0);
                    ready_ctr++;
                    mem_ready = rdy;
                    if (mem_req) begin
                        if (beat_q.size() == 0) begin
                            chk("unexpected_beat", {mem_we, mem_addr}, '0);
                        end else begin
                            b = beat_q[0];
                            chk("beat_addr", mem_addr, b.addr);
                            chk("beat_we", mem_we, b.we);
                            if (b.we) chk("beat_wdata", mem_wdata, b.data);
                            if (rdy) void'(beat_q.pop_front());
                        end
                        if (rdy) begin
                            accepts++;
                            if (mem_we) begin
                                mem_model[mem_addr] = mem_wdata;
                            end else begin
                                ret_q.push_back('{data: mem_model.exists(mem_addr) ?
                                                        mem_model[mem_addr] : 64'hDEAD,
                                                  due: cyc + lat});
                            end
                        end
                    end
                end
                if (dreqack) begin
                    ack_cyc = cyc;
                    chk("ack_done_overlap", ddone, 1'b0);
                end
                if (ddone) begin
                    if (txn_q.size() == 0) begin
                        chk("spurious_ddone", ddone, 1'b0);
                    end else begin
                        t = txn_q.pop_front();
                        chk({t.name, "_drdata"}, drdata, t.line);
                        if (t.lat >= 0) chk({t.name, "_latency"}, 512'(cyc - ack_cyc), 512'(t.lat));
                        $display("txn %s ddone at cycle %0d drdata[63:0]=%0h", t.name, cyc,
                                 drdata[63:0]);
                    end
                end
            end
        end
    end

    // Caller must be at a negedge with the DUT idle
    task automatic start_req(input logic we, input logic [63:0] addr,
                             input logic [L*W-1:0] wline, input logic [L*W-1:0] exp_line,
                             input int exp_lat, input string nm);
        logic [63:0] base;
        base = addr & ~64'h3F;
        for (int i = 0; i < L; i++) begin
            beat_q.push_back('{we: we, addr: base + 64'(8 * i), data: wline[64*i +: 64]});
        end
        txn_q.push_back('{line: exp_line, lat: exp_lat, name: nm});
        drequest  = 1'b1;
        dwrenable = we;
        daddr     = addr;
        dwdata    = wline;
        @(negedge clk);
        chk({nm, "_dreqack"}, dreqack, 1'b1);
        drequest  = 1'b0;
        dwrenable = ~we;
        daddr     = 64'hFFFF_FFFF_FFFF_FFC0;
        dwdata    = ~wline;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && txn_q.size() > 0; i++) @(negedge clk);
        chk("wait_idle_timeout", 512'(txn_q.size()), '0);
        txn_q.delete();
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_dreqack"}, dreqack, 1'b0);
        chk({nm, "_ddone"}, ddone, 1'b0);
        chk({nm, "_mem_req"}, mem_req, 1'b0);
        chk({nm, "_mem_we"}, mem_we, 1'b0);
        chk({nm, "_mem_addr"}, mem_addr, '0);
        chk({nm, "_mem_wdata"}, mem_wdata, '0);
        chk({nm, "_drdata"}, drdata, '0);
        chk({nm, "_proto_err"}, proto_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start_acc;
        int i;
        reset     = 1'b1;
        drequest  = 1'b0;
        dwrenable = 1'b0;
        daddr     = '0;
        dwdata    = '0;
        for (int k = 0; k < L; k++) begin
            mem_model[64'h1000 + 64'(8 * k)] = 64'hA0 + 64'(k);
            mem_model[64'h3000 + 64'(8 * k)] = 64'hC0 + 64'(k);
            mem_model[64'h4000 + 64'(8 * k)] = 64'hD0 + 64'(k);
            mem_model[64'h5000 + 64'(8 * k)] = 64'hE0 + 64'(k);
        end
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;

        // Ideal-memory read and write-back
        start_req(1'b0, 64'h1000, '0, mk_line(64'hA0), 10, "rd1000");
        wait_idle();
        start_req(1'b1, 64'h2000, mk_line(64'h0), mk_line(64'hA0), 9, "wb2000");
        wait_idle();

        // Stalling memory with long read latency
        ready_mode = 1;
        lat = 3;
        start_req(1'b0, 64'h5000, '0, mk_line(64'hE0), -1, "rd5000_stall");
        wait_idle();
        ready_mode = 0;
        lat = 1;
        repeat (4) @(negedge clk);

        // Write-back followed by a fill requested in its ddone cycle
        start_req(1'b1, 64'h2040, mk_line(64'h10), mk_line(64'hE0), 9, "wb2040");
        for (i = 0; i < 50 && !ddone; i++) @(negedge clk);
        chk("b2b_ddone_seen", ddone, 1'b1);
        start_req(1'b0, 64'h3000, '0, mk_line(64'hC0), 10, "rd3000_b2b");
        wait_idle();

        // Low address bits ignored
        start_req(1'b0, 64'h103F, '0, mk_line(64'hA0), 10, "rd103f");
        wait_idle();

        // Reset mid-read, late beats must not flag an error
        lat = 3;
        start_acc = accepts;
        start_req(1'b0, 64'h1000, '0, '0, -1, "rd_reset");
        for (i = 0; i < 50 && (accepts - start_acc) < 4; i++) @(negedge clk);
        chk("reset_beats_reached", 512'(accepts - start_acc >= 4), 512'(1));
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("midreset");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_reset_proto_err", proto_err, 1'b0);
        chk("post_reset_no_ddone", ddone, 1'b0);
        lat = 1;
        start_req(1'b0, 64'h4000, '0, mk_line(64'hD0), 10, "rd4000");
        wait_idle();

        // Stray read beat while idle
        repeat (2) @(negedge clk);
        chk("pre_stray_proto_err", proto_err, 1'b0);
        stray_cnt++;
        repeat (3) @(negedge clk);
        chk("stray_proto_err", proto_err, 1'b1);
        repeat (5) @(negedge clk);
        chk("stray_proto_err_held", proto_err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
